gshare_branch_predictor: RTL and testbench
==========================================

Name: gshare_branch_predictor

Overview:
- Parametrised successor to the fixed 2-bit branch predictor used by the 5-stage core.
- Adds a tagged BTB of configurable depth, a gshare PHT indexed by PC XOR global history, and saturating mispredict statistics.
- Sits in IF: it predicts combinationally from the fetch PC.
- It is updated from ID when a branch resolves; the core carries pred_meta through the IF/ID register.

Parameters:
XLEN, 32, address/data width
BTB_ENTRIES, 16, BTB depth; power of 2, >=2
PHT_ENTRIES, 256, pattern history table depth; power of 2, >=2
GHR_BITS, 8, global history length, >=1
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
pc_fetch  in  XLEN  PC being fetched
pred_taken  out  1  predicted taken
pred_target  out  XLEN  predicted next PC
pred_meta  out  PI+1  {pred_taken, pht_index}; PI = log2(PHT_ENTRIES)
update_en  in  1  branch resolved this cycle
upd_pc  in  XLEN  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual taken target
upd_meta  in  PI+1  pred_meta captured at fetch of that branch
branch_count  out  CNT_W  resolved branches since reset
mispredict_count  out  CNT_W  mispredicted branches since reset

Behaviour:
Derived widths and fields:
- BI = log2(BTB_ENTRIES).
- BTB index = pc[BI+1:2].
- Tag = pc[XLEN-1:BI+2].
- Per BTB entry: valid, tag, target.

Prediction (combinational, zero latency):
- hist = GHR truncated to its low PI bits, or zero-extended if GHR_BITS < PI.
- pht_index = pc_fetch[PI+1:2] XOR hist.
- hit = valid[bidx] && tag[bidx] == pc_fetch tag.
- pred_taken = hit && pht[pht_index][1].
- pred_target = pred_taken ? btb_target[bidx] : pc_fetch+4, modulo 2^XLEN (wraps at 0xFFFFFFFC -> 0x0).
- pred_meta = {pred_taken, pht_index}.

Update (rising clk, only when update_en=1):
- PHT entry upd_meta[PI-1:0]: read-modify-write of the current table value.
  - +1 if upd_taken, -1 otherwise.
  - Saturates at 2'b11 and 2'b00.
- GHR <= {GHR[GHR_BITS-2:0], upd_taken}; for GHR_BITS=1, GHR <= upd_taken.
- BTB: if upd_taken, entry at upd_pc index <= {valid=1, upd_pc tag, upd_target}, overwriting any alias. A not-taken branch never modifies or invalidates the BTB.
- branch_count += 1, saturating at all-ones.
- mispredict_count += 1, saturating, when either:
  - upd_meta[PI] != upd_taken, or
  - upd_meta[PI]=1 and upd_taken=1 and the BTB target read at upd_pc index != upd_target (wrong target, or entry missing/aliased).

Update off:
- update_en=0: all state holds; upd_* inputs are ignored.

Simultaneous lookup and update of the same PHT/BTB entry:
- The prediction uses pre-update contents (no bypass).
- The new value is visible from the next cycle.

Reset (rst=0, asynchronous, any time including mid-update):
- Every PHT entry = 2'b01 (weakly not-taken).
- All BTB valid = 0.
- GHR = 0.
- Both counters = 0.
- Outputs during and after reset until the first update: pred_taken=0, pred_target=pc_fetch+4.
- An update coincident with the reset release edge is discarded.

Storage:
- Flop-based, so reset clears all state.

Test Plan:
- Reset release, pc_fetch=0x100 -> pred_taken=0, pred_target=0x104, pred_meta={0,0x40}, both counters 0.
- Two updates at upd_pc=0x100, taken, upd_target=0x80, using each cycle's pred_meta (GHR starts 0) -> after the second, with GHR=2'b11, fetch 0x100 gives pht_index=0x43. Train that index twice more, then fetch -> pred_taken=1, pred_target=0x80.
- Saturation: five consecutive taken updates on one index, then one not-taken -> counter 11 -> 10, prediction still taken. Three further not-taken -> counter 00; a further not-taken stays 00.
- BTB alias (BTB_ENTRIES=16): train taken 0x100->0x80, then taken 0x140->0x200. Fetch 0x100 -> tag miss, pred_taken=0, pred_target=0x104. Fetch 0x140 with a taken-state counter -> target 0x200.
- Statistics: 10 updates, 3 with upd_meta[PI] != upd_taken, 1 with right direction but wrong target -> branch_count=10, mispredict_count=4. Force count regs to all-ones, then update -> both hold all-ones.
- Reset asserted in the same cycle as update_en=1 while trained -> all tables, GHR and counters back to reset values; pred_taken=0 on the next fetch of 0x100.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// Gshare branch predictor for the IF stage: tagged BTB plus a PC^history indexed PHT.
// Predicts combinationally from the fetch PC and learns when ID resolves a branch.
`timescale 1ns/1ps
module gshare_branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int CNT_W       = 32,
  localparam int PI = $clog2(PHT_ENTRIES),
  localparam int BI = $clog2(BTB_ENTRIES),
  localparam int TW = XLEN - BI - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_fetch,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [PI:0]     pred_meta,
  input  logic            update_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic [PI:0]     upd_meta,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic [1:0]             pht_reg [PHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_reg;
  logic [TW-1:0]          btb_tag_reg [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target_reg [BTB_ENTRIES];
  logic [GHR_BITS-1:0]    ghr_reg;
  logic [GHR_BITS-1:0]    ghr_next;
  logic [CNT_W-1:0]       branch_count_reg;
  logic [CNT_W-1:0]       mispredict_count_reg;

  logic [PI-1:0]   hist;
  logic [BI-1:0]   fetch_bidx;
  logic [TW-1:0]   fetch_tag;
  logic [PI-1:0]   pht_index;
  logic            fetch_hit;

  logic [BI-1:0]   upd_bidx;
  logic [TW-1:0]   upd_tag;
  logic [PI-1:0]   upd_pht_index;
  logic [1:0]      pht_cur;
  logic [1:0]      pht_next;
  logic            upd_btb_ok;
  logic            mispredict;
  logic            unused_pc_bits;

  // History folded to the PHT index width: truncate long histories, zero-extend short ones.
  generate
    if (GHR_BITS >= PI) begin : g_hist_trunc
      assign hist = ghr_reg[PI-1:0];
    end else begin : g_hist_ext
      assign hist = {{(PI-GHR_BITS){1'b0}}, ghr_reg};
    end
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_next = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr_reg[GHR_BITS-2:0], upd_taken};
    end
  endgenerate

  assign unused_pc_bits = ^{pc_fetch[1:0], upd_pc[1:0]};

  assign fetch_bidx = pc_fetch[BI+1:2];
  assign fetch_tag  = pc_fetch[XLEN-1:BI+2];
  assign pht_index  = pc_fetch[PI+1:2] ^ hist;
  assign fetch_hit  = btb_valid_reg[fetch_bidx] && (btb_tag_reg[fetch_bidx] == fetch_tag);

  assign pred_taken  = fetch_hit && pht_reg[pht_index][1];
  assign pred_target = pred_taken ? btb_target_reg[fetch_bidx] : pc_fetch + XLEN'(4);
  assign pred_meta   = {pred_taken, pht_index};

  assign upd_bidx      = upd_pc[BI+1:2];
  assign upd_tag       = upd_pc[XLEN-1:BI+2];
  assign upd_pht_index = upd_meta[PI-1:0];
  assign pht_cur       = pht_reg[upd_pht_index];

  always_comb begin
    pht_next = pht_cur;
    if (upd_taken) begin
      if (pht_cur != 2'b11) pht_next = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'b00) pht_next = pht_cur - 2'd1;
    end
  end

  // A predicted-taken branch is only right if the BTB entry it relied on still holds the real target.
  assign upd_btb_ok = btb_valid_reg[upd_bidx] && (btb_tag_reg[upd_bidx] == upd_tag)
                      && (btb_target_reg[upd_bidx] == upd_target);
  assign mispredict = (upd_meta[PI] != upd_taken) || (upd_meta[PI] && upd_taken && !upd_btb_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_reg[i] <= 2'b01;
      btb_valid_reg        <= '0;
      ghr_reg              <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else if (update_en) begin
      pht_reg[upd_pht_index] <= pht_next;
      ghr_reg                <= ghr_next;
      if (upd_taken) btb_valid_reg[upd_bidx] <= 1'b1;
      if (!(&branch_count_reg)) branch_count_reg <= branch_count_reg + CNT_W'(1);
      if (mispredict && !(&mispredict_count_reg))
        mispredict_count_reg <= mispredict_count_reg + CNT_W'(1);
    end
  end

  // Tag/target need no reset: they are never consulted while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (update_en && upd_taken && rst) begin
      btb_tag_reg[upd_bidx]    <= upd_tag;
      btb_target_reg[upd_bidx] <= upd_target;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: gshare indexing, saturation, BTB aliasing,
// statistics, reset during update, and counter saturation on a narrow-counter instance.
`timescale 1ns/1ps
module tb_gshare_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_fetch;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [8:0]  pred_meta;
  logic        update_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [8:0]  upd_meta;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic        s_update_en;
  logic [31:0] s_upd_pc;
  logic        s_upd_taken;
  logic [31:0] s_upd_target;
  logic [8:0]  s_upd_meta;
  logic [31:0] s_pc_fetch;
  logic        s_unused_taken;
  logic [31:0] s_unused_target;
  logic [8:0]  s_unused_meta;
  logic [1:0]  s_branch_count;
  logic [1:0]  s_mispredict_count;

  int vectors;
  int errors;

  gshare_branch_predictor dut (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_meta(pred_meta),
    .update_en(update_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_meta(upd_meta),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  gshare_branch_predictor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_fetch(s_pc_fetch),
    .pred_taken(s_unused_taken), .pred_target(s_unused_target), .pred_meta(s_unused_meta),
    .update_en(s_update_en), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
    .upd_target(s_upd_target), .upd_meta(s_upd_meta),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update_en   = 1'b0;
    s_update_en = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                           input logic [8:0] meta);
    update_en  = 1'b1;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
    upd_meta   = meta;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic [8:0] meta);
    drive_upd(pc, t, tgt, meta);
    tick();
  endtask

  // Eight updates on PC 0x100 (BTB target unchanged) into scratch PHT entry 0 leave GHR == g.
  task automatic set_ghr(input logic [7:0] g);
    for (int i = 7; i >= 0; i--) upd(32'h100, g[i], 32'h80, 9'h000);
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_fetch = pc;
    #1;
  endtask

  task automatic s_upd();
    s_update_en  = 1'b1;
    s_upd_pc     = 32'h100;
    s_upd_taken  = 1'b0;
    s_upd_target = 32'h0;
    s_upd_meta   = 9'h100;
    tick();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b0;
    pc_fetch = 32'h100;
    update_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_meta = '0;
    s_update_en = 1'b0; s_upd_pc = '0; s_upd_taken = 1'b0; s_upd_target = '0; s_upd_meta = '0;
    s_pc_fetch = 32'h100;

    #1;
    check("in_reset_taken", pred_taken, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    fetch(32'h100);
    check("rst_taken", pred_taken, 1'b0);
    check("rst_target", pred_target, 32'h104);
    check("rst_meta", pred_meta, 9'h040);
    check("rst_bcount", branch_count, 32'd0);
    check("rst_mcount", mispredict_count, 32'd0);

    upd(32'h100, 1'b1, 32'h80, pred_meta);
    fetch(32'h100);
    check("ghr1_meta", pred_meta, 9'h041);
    upd(32'h100, 1'b1, 32'h80, pred_meta);
    fetch(32'h100);
    check("ghr3_meta", pred_meta, 9'h043);
    check("ghr3_taken", pred_taken, 1'b0);
    upd(32'h130, 1'b1, 32'h80, 9'h043);
    upd(32'h130, 1'b1, 32'h80, 9'h043);
    fetch(32'h130);
    check("xor_taken", pred_taken, 1'b1);
    check("xor_target", pred_target, 32'h80);
    check("xor_meta", pred_meta, 9'h143);

    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h80, 9'h050);
    upd(32'h100, 1'b0, 32'h80, 9'h050);
    set_ghr(8'h10);
    fetch(32'h100);
    check("sat_hi_taken", pred_taken, 1'b1);
    check("sat_hi_target", pred_target, 32'h80);
    check("sat_hi_meta", pred_meta, 9'h150);
    for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 32'h80, 9'h050);
    set_ghr(8'h10);
    fetch(32'h100);
    check("sat_00_taken", pred_taken, 1'b0);
    check("sat_00_meta", pred_meta, 9'h050);
    upd(32'h100, 1'b0, 32'h80, 9'h050);
    upd(32'h100, 1'b1, 32'h80, 9'h050);
    set_ghr(8'h10);
    fetch(32'h100);
    check("sat_lo_taken", pred_taken, 1'b0);
    drive_upd(32'h100, 1'b1, 32'h80, 9'h050);
    #1;
    check("no_bypass_taken", pred_taken, 1'b0);
    tick();
    set_ghr(8'h10);
    fetch(32'h100);
    check("post_upd_taken", pred_taken, 1'b1);

    upd(32'h100, 1'b1, 32'h80, 9'h051);
    upd(32'h100, 1'b1, 32'h80, 9'h051);
    set_ghr(8'h08);
    upd(32'h140, 1'b1, 32'h200, 9'h0AA);
    fetch(32'h100);
    check("alias_miss_taken", pred_taken, 1'b0);
    check("alias_miss_target", pred_target, 32'h104);
    fetch(32'h140);
    check("alias_hit_taken", pred_taken, 1'b1);
    check("alias_hit_target", pred_target, 32'h200);
    check("alias_hit_meta", pred_meta, 9'h141);
    fetch(32'hFFFF_FFFC);
    check("wrap_taken", pred_taken, 1'b0);
    check("wrap_target", pred_target, 32'h0);

    fetch(32'h140);
    drive_upd(32'h140, 1'b1, 32'h200, 9'h141);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_taken", pred_taken, 1'b0);
    check("async_rst_bcount", branch_count, 32'd0);
    tick();
    @(posedge clk);
    #1;
    rst = 1'b1;
    fetch(32'h140);
    check("post_rst_taken_140", pred_taken, 1'b0);
    check("post_rst_target_140", pred_target, 32'h144);
    check("post_rst_meta_140", pred_meta, 9'h050);
    check("post_rst_bcount", branch_count, 32'd0);
    check("post_rst_mcount", mispredict_count, 32'd0);
    fetch(32'h100);
    check("post_rst_meta_100", pred_meta, 9'h040);

    upd(32'h100, 1'b0, 32'h0,  9'h000);
    upd(32'h100, 1'b0, 32'h0,  9'h100);
    upd(32'h100, 1'b1, 32'h80, 9'h000);
    upd(32'h100, 1'b1, 32'h80, 9'h100);
    upd(32'h100, 1'b1, 32'h90, 9'h100);
    check("stats5_bcount", branch_count, 32'd5);
    check("stats5_mcount", mispredict_count, 32'd3);
    upd(32'h100, 1'b1, 32'h90, 9'h100);
    upd(32'h104, 1'b0, 32'h0,  9'h000);
    upd(32'h108, 1'b1, 32'h10, 9'h000);
    upd(32'h108, 1'b1, 32'h10, 9'h100);
    upd(32'h100, 1'b0, 32'h0,  9'h000);
    check("stats10_bcount", branch_count, 32'd10);
    check("stats10_mcount", mispredict_count, 32'd4);

    update_en = 1'b0;
    upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h999; upd_meta = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    check("upd_off_bcount", branch_count, 32'd10);
    check("upd_off_mcount", mispredict_count, 32'd4);

    s_upd();
    s_upd();
    check("narrow2_bcount", s_branch_count, 2'd2);
    check("narrow2_mcount", s_mispredict_count, 2'd2);
    s_upd();
    s_upd();
    s_upd();
    check("narrow_sat_bcount", s_branch_count, 2'b11);
    check("narrow_sat_mcount", s_mispredict_count, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
